// File: rtl/capture_ctrl_pkg.sv
// Shared capture-path definitions: sample RAM geometry, capture states and
// a helper that tells whether a state is part of an active acquisition.
package dso_capture_pkg;

    localparam int ENTRIES = 512;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_t;

    function automatic logic is_active(input cap_state_t s);
        return (s == PRE) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Command, trigger handshake and sample RAM write port of the capture controller.
interface capture_ctrl_if;

    logic                        run;
    logic                        stop;
    logic                        clr_done;
    logic [3:0]                  decimator;
    logic [dso_capture_pkg::AW-1:0] trig_pos;
    logic                        triggered;

    logic                        we;
    logic [dso_capture_pkg::AW-1:0] waddr;
    logic                        trig_en;
    logic                        armed;
    logic                        set_capture_done;
    logic                        capture_done;
    logic [dso_capture_pkg::AW-1:0] trace_end;
    logic                        busy;

    modport master (
        output run, stop, clr_done, decimator, trig_pos, triggered,
        input  we, waddr, trig_en, armed, set_capture_done, capture_done, trace_end, busy
    );

    modport slave (
        input  run, stop, clr_done, decimator, trig_pos, triggered,
        output we, waddr, trig_en, armed, set_capture_done, capture_done, trace_end, busy
    );

endinterface

// File: rtl/capture_ctrl_smpl_strobe.sv
// Decimation counter: produces a sample strobe once every 2^decimator clocks
// while enabled, starting from a cleared count.
module smpl_strobe
    import dso_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] decimator,
    output logic       strobe
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] mask;

    // Next count: clear on a new capture, otherwise free-run while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobe when the low decimator bits are all ones; an empty mask fires every cycle.
    always_comb begin
        mask   = CW'((32'd1 << decimator) - 32'd1);
        strobe = en && ((cnt_q & mask) == mask);
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: fills the circular sample RAM with pre-trigger history,
// waits for the trigger, stores the post-trigger samples and reports the trace end.
module capture_ctrl
    import dso_capture_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    capture_ctrl_if.slave bus
);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   smpl_cnt_q, smpl_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0] trig_pos_q, trig_pos_d;
    logic [3:0]    dec_q, dec_d;
    logic [AW-1:0] trace_end_q, trace_end_d;
    logic          capture_done_q, capture_done_d;
    logic          set_capture_done_q, set_capture_done_d;
    logic          trig_en_q, trig_en_d;
    logic          armed_q, armed_d;

    logic          busy;
    logic          strobe;
    logic          we;
    logic          run_ok;
    logic          enter_done;
    logic [AW:0]   pre_target;

    smpl_strobe u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (run_ok),
        .en        (busy),
        .decimator (dec_q),
        .strobe    (strobe)
    );

    // Next-state, counters and status; stop overrides everything, and a run
    // landing on the done pulse is refused because the trace is not yet final.
    always_comb begin
        state_d        = state_q;
        waddr_d        = waddr_q;
        smpl_cnt_d     = smpl_cnt_q;
        post_cnt_d     = post_cnt_q;
        trig_pos_d     = trig_pos_q;
        dec_d          = dec_q;
        trace_end_d    = trace_end_q;
        capture_done_d = capture_done_q;

        busy       = is_active(state_q);
        we         = strobe && busy;
        run_ok     = bus.run && ((state_q == IDLE) || ((state_q == DONE) && !set_capture_done_q));
        pre_target = (AW+1)'(ENTRIES) - {1'b0, trig_pos_q};

        if (we) begin
            waddr_d = waddr_q + 1'b1;
        end

        case (state_q)
            PRE: begin
                if (we) begin
                    smpl_cnt_d = smpl_cnt_q + 1'b1;
                    if (smpl_cnt_d == pre_target) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (bus.triggered) begin
                    post_cnt_d = '0;
                    state_d    = (trig_pos_q == '0) ? DONE : POST;
                end
            end
            POST: begin
                if (we) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == {1'b0, trig_pos_q}) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
            end
        endcase

        if (run_ok) begin
            state_d    = PRE;
            waddr_d    = '0;
            smpl_cnt_d = '0;
            post_cnt_d = '0;
            trig_pos_d = bus.trig_pos;
            dec_d      = bus.decimator;
        end

        if (bus.stop) begin
            state_d = IDLE;
            waddr_d = waddr_q;
        end

        enter_done         = (state_d == DONE) && (state_q != DONE);
        set_capture_done_d = enter_done;
        trig_en_d          = is_active(state_d);
        armed_d            = (state_d == ARMED);

        if (enter_done) begin
            capture_done_d = 1'b1;
            trace_end_d    = waddr_d;
        end else if (bus.clr_done || run_ok) begin
            capture_done_d = 1'b0;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            waddr_q            <= '0;
            smpl_cnt_q         <= '0;
            post_cnt_q         <= '0;
            trig_pos_q         <= '0;
            dec_q              <= '0;
            trace_end_q        <= '0;
            capture_done_q     <= 1'b0;
            set_capture_done_q <= 1'b0;
            trig_en_q          <= 1'b0;
            armed_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            waddr_q            <= waddr_d;
            smpl_cnt_q         <= smpl_cnt_d;
            post_cnt_q         <= post_cnt_d;
            trig_pos_q         <= trig_pos_d;
            dec_q              <= dec_d;
            trace_end_q        <= trace_end_d;
            capture_done_q     <= capture_done_d;
            set_capture_done_q <= set_capture_done_d;
            trig_en_q          <= trig_en_d;
            armed_q            <= armed_d;
        end
    end

    assign bus.we               = we;
    assign bus.waddr            = waddr_q;
    assign bus.trig_en          = trig_en_q;
    assign bus.armed            = armed_q;
    assign bus.set_capture_done = set_capture_done_q;
    assign bus.capture_done     = capture_done_q;
    assign bus.trace_end        = trace_end_q;
    assign bus.busy             = busy;

endmodule
